// File: rtl/led_write_sequencer.sv
// led_write_sequencer
// Two-port round-robin front end for the LED peripheral register bus.
// An accepted command becomes a fixed bus program:
//   pattern: D1 <= pattern[15:8], D2 <= pattern[7:0], then park on CTRL = 1
//   blank  : park on CTRL = 0
// Each beat is held BEAT_CYCLES cycles (legal 2..15) so the peripheral's
// one-cycle input register always captures a settled value. Between
// transfers the bus rests on the control register and never on an unmapped
// address, which would clear the display.
module led_write_sequencer #(
    parameter int unsigned BEAT_CYCLES = 2,
    parameter logic [7:0]  ADDR_CTRL   = 8'h01,
    parameter logic [7:0]  ADDR_D1     = 8'h02,
    parameter logic [7:0]  ADDR_D2     = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic [15:0] req0_pattern,
    input  logic        req0_blank,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [15:0] req1_pattern,
    input  logic        req1_blank,
    output logic        req1_ready,

    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_wr_en,

    output logic        busy,
    output logic        grant_id,
    output logic        done
);

    // Sequencer states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_HI   = 2'd1;
    localparam logic [1:0] S_WR_LO   = 2'd2;
    localparam logic [1:0] S_WR_CTRL = 2'd3;

    // Last beat index; beat_cnt counts 0..BEAT_LAST in every active state
    localparam logic [3:0] BEAT_LAST = 4'(BEAT_CYCLES - 1);

    logic [1:0]  state, state_nxt;
    logic [3:0]  beat_cnt, beat_nxt;
    logic [15:0] pattern_q;
    logic        blank_q;
    logic        enabled, enabled_nxt;
    logic        last_grant;

    logic        is_idle;
    logic        beat_end;
    logic        acc0, acc1, accept;
    logic [15:0] pattern_sel;
    logic        blank_sel;
    logic [15:0] pattern_eff;
    logic        blank_eff;

    logic [7:0]  bus_addr_nxt;
    logic [7:0]  bus_wdata_nxt;
    logic        bus_wr_en_nxt;
    logic        done_nxt;

    assign is_idle  = (state == S_IDLE);
    assign beat_end = (beat_cnt == BEAT_LAST);

    // Round-robin arbitration, only offered while idle and out of reset
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (is_idle && rst_n) begin
            if (req0_valid && req1_valid) begin
                // last_grant == 1 means requester 1 went last, so 0 wins
                req0_ready = last_grant;
                req1_ready = ~last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign acc0   = req0_valid && req0_ready;
    assign acc1   = req1_valid && req1_ready;
    assign accept = acc0 || acc1;

    // Command payload of the winning port
    assign pattern_sel = acc1 ? req1_pattern : req0_pattern;
    assign blank_sel   = acc1 ? req1_blank   : req0_blank;

    // Payload the next bus value is built from: fresh on accept, else latched
    assign pattern_eff = accept ? pattern_sel : pattern_q;
    assign blank_eff   = accept ? blank_sel   : blank_q;

    // Next-state and beat counter sequencing
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat_cnt;
        enabled_nxt = enabled;
        case (state)
            S_IDLE: begin
                beat_nxt = 4'd0;
                if (accept) begin
                    state_nxt = blank_sel ? S_WR_CTRL : S_WR_HI;
                end
            end
            S_WR_HI: begin
                if (beat_end) begin
                    state_nxt = S_WR_LO;
                    beat_nxt  = 4'd0;
                end else begin
                    beat_nxt  = beat_cnt + 4'd1;
                end
            end
            S_WR_LO: begin
                if (beat_end) begin
                    state_nxt = S_WR_CTRL;
                    beat_nxt  = 4'd0;
                end else begin
                    beat_nxt  = beat_cnt + 4'd1;
                end
            end
            S_WR_CTRL: begin
                if (beat_end) begin
                    state_nxt   = S_IDLE;
                    beat_nxt    = 4'd0;
                    enabled_nxt = ~blank_q;
                end else begin
                    beat_nxt    = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                beat_nxt  = 4'd0;
            end
        endcase
    end

    // Bus value for the coming cycle, decoded from the next state so the
    // registered outputs line up with the state they describe
    always_comb begin
        bus_addr_nxt  = ADDR_CTRL;
        bus_wdata_nxt = {7'b0, enabled_nxt};
        bus_wr_en_nxt = 1'b0;
        case (state_nxt)
            S_WR_HI: begin
                bus_addr_nxt  = ADDR_D1;
                bus_wdata_nxt = pattern_eff[15:8];
                bus_wr_en_nxt = 1'b1;
            end
            S_WR_LO: begin
                bus_addr_nxt  = ADDR_D2;
                bus_wdata_nxt = pattern_eff[7:0];
                bus_wr_en_nxt = 1'b1;
            end
            S_WR_CTRL: begin
                bus_addr_nxt  = ADDR_CTRL;
                bus_wdata_nxt = {7'b0, ~blank_eff};
                bus_wr_en_nxt = 1'b0;
            end
            default: begin
                bus_addr_nxt  = ADDR_CTRL;
                bus_wdata_nxt = {7'b0, enabled_nxt};
                bus_wr_en_nxt = 1'b0;
            end
        endcase
    end

    // done marks the final control beat of a sequence
    assign done_nxt = (state_nxt == S_WR_CTRL) && (beat_nxt == BEAT_LAST);

    // Sequencer state, beat counter and display-enable memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= 4'd0;
            enabled  <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            enabled  <= enabled_nxt;
        end
    end

    // Command capture and arbitration history, updated only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q  <= 16'h0000;
            blank_q    <= 1'b0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
        end else if (accept) begin
            pattern_q  <= pattern_sel;
            blank_q    <= blank_sel;
            last_grant <= acc1;
            grant_id   <= acc1;
        end
    end

    // Registered bus and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= ADDR_CTRL;
            bus_wdata <= 8'h00;
            bus_wr_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bus_addr  <= bus_addr_nxt;
            bus_wdata <= bus_wdata_nxt;
            bus_wr_en <= bus_wr_en_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_led_write_sequencer.sv
// tb_led_write_sequencer
// Two sequencers (BEAT_CYCLES 2 and 4) share one pair of requesters. A
// transaction-level model predicts ready and every registered output from
// the command stream: each accepted command is a timeline of 3*B (pattern)
// or B (blank) cycles whose bus value is picked by offset/B.
module tb_led_write_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, v1 = 1'b0, bl0 = 1'b0, bl1 = 1'b0;
    logic [15:0] p0 = 16'h0, p1 = 16'h0;

    logic       r0 [2];
    logic       r1 [2];
    logic [7:0] b_addr [2];
    logic [7:0] b_wdata [2];
    logic       b_wr [2];
    logic       b_busy [2];
    logic       b_done [2];
    logic       b_gid [2];

    led_write_sequencer #(.BEAT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_pattern(p0), .req0_blank(bl0), .req0_ready(r0[0]),
        .req1_valid(v1), .req1_pattern(p1), .req1_blank(bl1), .req1_ready(r1[0]),
        .bus_addr(b_addr[0]), .bus_wdata(b_wdata[0]), .bus_wr_en(b_wr[0]),
        .busy(b_busy[0]), .grant_id(b_gid[0]), .done(b_done[0])
    );

    led_write_sequencer #(.BEAT_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_pattern(p0), .req0_blank(bl0), .req0_ready(r0[1]),
        .req1_valid(v1), .req1_pattern(p1), .req1_blank(bl1), .req1_ready(r1[1]),
        .bus_addr(b_addr[1]), .bus_wdata(b_wdata[1]), .bus_wr_en(b_wr[1]),
        .busy(b_busy[1]), .grant_id(b_gid[1]), .done(b_done[1])
    );

    typedef struct packed { logic [15:0] pat; logic blank; } cmd_t;
    cmd_t q0 [$];
    cmd_t q1 [$];
    int   glog [$];
    bit   rnd_hold = 1'b0;
    int   total = 0, bad = 0;
    int   done_cnt = 0, busy_cnt = 0;

    // reference model state per DUT
    bit          m_busy [2];
    int          m_off [2];
    int          m_len [2];
    logic [15:0] m_pat [2];
    bit          m_blank [2];
    bit          m_lg [2];
    bit          m_gid [2];
    bit          m_en [2];
    bit          mr0 [2];
    bit          mr1 [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int beats(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_regs(input int d);
        logic [7:0] a, w;
        logic wr, by, dn;
        int seg;
        if (m_busy[d]) begin
            seg = m_blank[d] ? 2 : m_off[d] / beats(d);
            case (seg)
                0:       begin a = 8'h02; w = m_pat[d][15:8]; wr = 1'b1; end
                1:       begin a = 8'h03; w = m_pat[d][7:0];  wr = 1'b1; end
                default: begin a = 8'h01; w = {7'b0, ~m_blank[d]}; wr = 1'b0; end
            endcase
            by = 1'b1;
            dn = (m_off[d] == m_len[d] - 1);
        end else begin
            a = 8'h01; w = {7'b0, m_en[d]}; wr = 1'b0; by = 1'b0; dn = 1'b0;
        end
        return 32'({a, w, wr, by, dn, m_gid[d]});
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_off[d] = 0; m_len[d] = 0; m_pat[d] = 16'h0;
            m_blank[d] = 0; m_lg[d] = 1; m_gid[d] = 0; m_en[d] = 0;
        end
    endtask

    task automatic model_ready();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n || m_busy[d]) begin
                mr0[d] = 0; mr1[d] = 0;
            end else if (v0 && v1) begin
                mr0[d] = m_lg[d]; mr1[d] = !m_lg[d];
            end else begin
                mr0[d] = v0; mr1[d] = v1;
            end
        end
    endtask

    // advance each timeline by one clock; pops follow DUT0's handshake
    task automatic model_step();
        bit a0, a1;
        a0 = v0 && mr0[0];
        a1 = v1 && mr1[0];
        for (int d = 0; d < 2; d++) begin
            if (!m_busy[d]) begin
                if ((v0 && mr0[d]) || (v1 && mr1[d])) begin
                    m_busy[d]  = 1;
                    m_off[d]   = 0;
                    m_gid[d]   = (v1 && mr1[d]);
                    m_lg[d]    = m_gid[d];
                    m_pat[d]   = m_gid[d] ? p1 : p0;
                    m_blank[d] = m_gid[d] ? bl1 : bl0;
                    m_len[d]   = m_blank[d] ? beats(d) : 3 * beats(d);
                end
            end else begin
                m_off[d]++;
                if (m_off[d] == m_len[d]) begin
                    m_busy[d] = 0;
                    m_en[d]   = !m_blank[d];
                end
            end
        end
        if (a0) begin void'(q0.pop_front()); glog.push_back(0); end
        if (a1) begin void'(q1.pop_front()); glog.push_back(1); end
    endtask

    task automatic drive();
        bit h0, h1;
        h0 = rnd_hold && ($urandom_range(0, 3) == 0);
        h1 = rnd_hold && ($urandom_range(0, 3) == 0);
        if (q0.size() != 0) begin
            v0 = !h0; p0 = q0[0].pat; bl0 = q0[0].blank;
        end else begin
            v0 = 1'b0; p0 = 16'($urandom); bl0 = 1'($urandom);
        end
        if (q1.size() != 0) begin
            v1 = !h1; p1 = q1[0].pat; bl1 = q1[0].blank;
        end else begin
            v1 = 1'b0; p1 = 16'($urandom); bl1 = 1'($urandom);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s%0d", tag, d),
                32'({b_addr[d], b_wdata[d], b_wr[d], b_busy[d], b_done[d], b_gid[d]}),
                exp_regs(d));
    endtask

    task automatic check_ready(input string tag);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s%0d", tag, d), 32'({r0[d], r1[d]}), 32'({mr0[d], mr1[d]}));
    endtask

    // one clock: drive at negedge, check ready, step, check registers
    task automatic cycle();
        drive();
        #1;
        model_ready();
        check_ready("ready");
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (b_done[0]) done_cnt++;
        if (b_busy[0]) busy_cnt++;
        check_regs("regs");
    endtask

    // asynchronous reset, checked while still asserted
    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        #1;
        model_reset();
        model_ready();
        check_regs("rst_regs");
        check_ready("rst_ready");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int max, input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy[0] || m_busy[1]) && n < max) begin
            cycle();
            n++;
        end
        chk({tag, "_in_budget"}, 32'(n < max), 32'd1);
        for (int i = 0; i < 3; i++) cycle();
    endtask

    initial begin
        int n;
        #2;
        do_reset();

        // single pattern from requester 0
        q0.push_back(cmd_t'{16'hCCAA, 1'b0});
        done_cnt = 0;
        run(50, "s1");
        chk("s1_done_cnt", 32'(done_cnt), 32'd1);
        chk("s1_idle_bus", 32'({b_addr[0], b_wdata[0], b_wr[0]}), 32'({8'h01, 8'h01, 1'b0}));

        // simultaneous requests right after reset
        do_reset();
        glog.delete();
        q0.push_back(cmd_t'{16'h1234, 1'b0});
        q1.push_back(cmd_t'{16'hABCD, 1'b0});
        run(80, "s2");
        chk("s2_ngrants", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            chk("s2_grant0", 32'(glog[0]), 32'd0);
            chk("s2_grant1", 32'(glog[1]), 32'd1);
        end
        chk("s2_gid", 32'(b_gid[0]), 32'd1);

        // blank from requester 1 after a pattern is showing
        q1.push_back(cmd_t'{16'h5555, 1'b1});
        done_cnt = 0;
        busy_cnt = 0;
        run(50, "s3");
        chk("s3_done_cnt", 32'(done_cnt), 32'd1);
        chk("s3_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("s3_idle_wdata", 32'(b_wdata[0]), 32'h00);

        // continuous contention alternates grants
        do_reset();
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(cmd_t'{16'($urandom), 1'b0});
            q1.push_back(cmd_t'{16'($urandom), 1'b0});
        end
        busy_cnt = 0;
        run(200, "s4");
        chk("s4_ngrants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < glog.size() && i < 8; i++)
            chk($sformatf("s4_grant%0d", i), 32'(glog[i]), 32'(i % 2));
        chk("s4_busy_cycles", 32'(busy_cnt), 32'd48);

        // reset pulled during the low-byte beat
        do_reset();
        q0.push_back(cmd_t'{16'h5A3C, 1'b0});
        n = 0;
        while (!(m_busy[0] && m_off[0] == 2) && n < 20) begin
            cycle();
            n++;
        end
        chk("s5_in_wrlo", 32'(b_addr[0]), 32'h03);
        q0.push_back(cmd_t'{16'h0F0F, 1'b0});
        done_cnt = 0;
        do_reset();
        drive();
        #1;
        chk("s5_rdy_after_rst", 32'(r0[0]), 32'd1);
        run(60, "s5");
        chk("s5_done_cnt", 32'(done_cnt), 32'd1);

        // randomized traffic with valid dropouts and blanks
        do_reset();
        rnd_hold = 1'b1;
        for (int i = 0; i < 30; i++) begin
            q0.push_back(cmd_t'{16'($urandom), 1'($urandom_range(0, 3) == 0)});
            q1.push_back(cmd_t'{16'($urandom), 1'($urandom_range(0, 3) == 0)});
        end
        run(3000, "s6");
        rnd_hold = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_write_sequencer.md
# led_write_sequencer

Sequencer and two-port arbiter in front of the LED peripheral's register bus. It accepts 16-bit LED patterns, or blank commands, from two requesters over valid/ready. It then drives the peripheral's `data_address` / `write_data` / `wr_en` inputs through the high-byte write, the low-byte write and the control-enable write, holding each beat long enough for the peripheral's one-cycle input registering. Between transfers it parks the bus on the control register, so the displayed pattern is held rather than cleared.

## Interface
- `BEAT_CYCLES`, 2: cycles each bus beat is held; legal range 2..15.
- `ADDR_CTRL`, 8'h01: LED control register address.
- `ADDR_D1`, 8'h02: LED data register 1 (high byte, `led[15:8]`).
- `ADDR_D2`, 8'h03: LED data register 2 (low byte, `led[7:0]`).

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a command.
- `req0_pattern`  in  16  requester 0 LED pattern.
- `req0_blank`  in  1  1 = blank command (pattern ignored).
- `req0_ready`  out  1  requester 0 command accepted this cycle when valid.
- `req1_valid`, `req1_pattern`, `req1_blank`, `req1_ready`: same as requester 0, for requester 1.
- `bus_addr`  out  8  to peripheral `data_address`.
- `bus_wdata`  out  8  to peripheral `write_data`.
- `bus_wr_en`  out  1  to peripheral `wr_en`.
- `busy`  out  1  sequence in progress.
- `grant_id`  out  1  requester of the current or most recent command.
- `done`  out  1  one-cycle pulse on the last cycle of a sequence.

## Operation
- States: IDLE, WR_HI, WR_LO, WR_CTRL. Beat counter `beat_cnt` runs 0..BEAT_CYCLES-1 in every non-IDLE state.
- Arbitration happens in IDLE only.
  - `ready` goes combinationally to exactly one requester: the only valid one, or, if both are valid, the one not granted last (round-robin).
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - Both `ready` outputs are 0 outside IDLE.
- Accept means `valid && ready`. On accept:
  - latch pattern and blank flag;
  - set `grant_id` and `last_grant`;
  - pattern command: go to WR_HI; blank command: go to WR_CTRL.
- WR_HI: bus = {ADDR_D1, pattern[15:8], wr_en=1}. After BEAT_CYCLES cycles, go to WR_LO.
- WR_LO: bus = {ADDR_D2, pattern[7:0], wr_en=1}. After BEAT_CYCLES cycles, go to WR_CTRL.
- WR_CTRL: bus = {ADDR_CTRL, 8'h01 for pattern or 8'h00 for blank, wr_en=0}. After BEAT_CYCLES cycles, go to IDLE.
  - `done`=1 on the final WR_CTRL cycle.
  - `enabled` register updates at that edge: 1 after a pattern, 0 after a blank.
- IDLE bus = {ADDR_CTRL, {7'b0, enabled}, wr_en=0}. The bus never idles on an unmapped address, because the peripheral clears the LEDs on one.
- `busy` = (state != IDLE).
- Pattern and blank inputs are sampled only at accept; later changes are ignored.

## Timing
- `bus_addr`, `bus_wdata`, `bus_wr_en`, `busy`, `done` and `grant_id` are registered.
- Accept at edge T. First WR_HI bus value is visible after T and held for BEAT_CYCLES cycles.
- Pattern sequence: 3×BEAT_CYCLES cycles busy. Blank sequence: BEAT_CYCLES cycles busy.
- Peripheral `led` shows the new pattern 2 cycles after the first WR_CTRL cycle (its input register plus output register).
- Back-to-back commands: the earliest next accept is the first IDLE cycle after `done`. Minimum spacing is 3×BEAT_CYCLES+1 cycles.
- Simultaneous valid on both ports in IDLE: exactly one ready, per round-robin. The loser stays pending and is accepted at the next IDLE.
- `valid` deasserted before ready: no transfer, no state change.
- Reset values: state IDLE, `bus_addr`=ADDR_CTRL, `bus_wdata`=8'h00, `bus_wr_en`=0, `busy`=0, `done`=0, `grant_id`=0, `req*_ready`=0, `enabled`=0, `last_grant`=1, `beat_cnt`=0.
- `rst_n` low mid-sequence: all state returns to reset values immediately (asynchronously), the in-flight command is dropped, and no `done` pulse is produced.

## Test plan
- Reset, then requester 0 sends pattern 16'hCCAA (BEAT_CYCLES=2). Bus shows 02/CC/wr1 for 2 cycles, then 03/AA/wr1 for 2, then 01/01/wr0 for 2. `done` pulses once. Peripheral `led`=16'hCCAA and stays there while IDLE.
- Both requesters valid in the same cycle after reset (0x1234 and 0xABCD). Requester 0 is granted first, requester 1 next. Final `led`=16'hABCD, `grant_id`=1.
- Requester 1 sends blank after a pattern has been shown. Bus shows 01/00/wr0 for 2 cycles, `busy` lasts 2 cycles, `led`=0, and IDLE `bus_wdata`=8'h00.
- Requester 0 holds valid continuously while requester 1 also requests. Grants alternate 0,1,0,1, and neither requester is starved.
- `rst_n` pulsed low during WR_LO. Bus immediately reads 01/00/wr0, `busy`=0, no `done`, and `req0_ready` reasserts in the first cycle after release.
- BEAT_CYCLES=4: pattern sequence is busy for exactly 12 cycles and each bus value is stable for 4 cycles.
